// File: rtl/axil_reg_walker.sv
// AXI4-Lite master that writes a pattern to a window of slave registers, reads each
// one back, compares, and reports pass/fail with capture of the first error seen.
module axil_reg_walker #(
    parameter int                    ADDR_WIDTH     = 32,
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    NUM_REGS       = 4,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
    parameter int                    ADDR_STRIDE    = 4,
    parameter int                    TIMEOUT_CYCLES = 256
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic                      start,
    input  logic [1:0]                mode,
    input  logic [DATA_WIDTH-1:0]     seed,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic                      timeout,
    output logic [7:0]                err_count,
    output logic [7:0]                first_err_index,
    output logic [DATA_WIDTH-1:0]     first_err_expected,
    output logic [DATA_WIDTH-1:0]     first_err_actual,
    output logic [1:0]                first_err_type,
    output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic [2:0]                m_axi_awprot,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    output logic [DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    input  logic [1:0]                m_axi_bresp,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready,
    output logic [ADDR_WIDTH-1:0]     m_axi_araddr,
    output logic [2:0]                m_axi_arprot,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    input  logic [DATA_WIDTH-1:0]     m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WR   = 3'd1;
    localparam logic [2:0] S_WB   = 3'd2;
    localparam logic [2:0] S_RA   = 3'd3;
    localparam logic [2:0] S_RD   = 3'd4;
    localparam logic [2:0] S_CMP  = 3'd5;
    localparam logic [2:0] S_DONE = 3'd6;
    localparam logic [2:0] S_HANG = 3'd7;

    localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]    LAST_IDX = 8'(NUM_REGS - 1);

    logic [2:0]            state_q, state_d;
    logic [7:0]            idx_q, idx_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [1:0]            mode_q, mode_d;
    logic [DATA_WIDTH-1:0] seed_q, seed_d;
    logic                  awv_q, awv_d;
    logic                  wv_q, wv_d;
    logic                  arv_q, arv_d;
    logic                  done_q, done_d;
    logic                  tmo_q, tmo_d;
    logic [TW-1:0]         tcnt_q, tcnt_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [7:0]            err_cnt_q, err_cnt_d;
    logic [7:0]            fe_idx_q, fe_idx_d;
    logic [DATA_WIDTH-1:0] fe_exp_q, fe_exp_d;
    logic [DATA_WIDTH-1:0] fe_act_q, fe_act_d;
    logic [1:0]            fe_type_q, fe_type_d;

    logic                  err_ev;
    logic [1:0]            err_ty;
    logic [DATA_WIDTH-1:0] err_act;
    logic [DATA_WIDTH-1:0] exp_data;
    logic                  wait_state;

    function automatic logic [DATA_WIDTH-1:0] gen_pattern(input logic [1:0] m,
                                                          input logic [DATA_WIDTH-1:0] s,
                                                          input logic [7:0] i);
        logic [DATA_WIDTH-1:0] sum;
        sum = s + DATA_WIDTH'(i);
        case (m)
            2'd0:    gen_pattern = s;
            2'd1:    gen_pattern = sum;
            2'd2:    gen_pattern = {{(DATA_WIDTH-1){1'b0}}, 1'b1} << (i & 8'(DATA_WIDTH - 1));
            default: gen_pattern = ~sum;
        endcase
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        sat_inc = (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    assign exp_data = gen_pattern(mode_q, seed_q, idx_q);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        addr_d    = addr_q;
        mode_d    = mode_q;
        seed_d    = seed_q;
        awv_d     = awv_q;
        wv_d      = wv_q;
        arv_d     = arv_q;
        done_d    = done_q;
        tmo_d     = tmo_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        err_cnt_d = err_cnt_q;
        fe_idx_d  = fe_idx_q;
        fe_exp_d  = fe_exp_q;
        fe_act_d  = fe_act_q;
        fe_type_d = fe_type_q;
        err_ev    = 1'b0;
        err_ty    = 2'd0;
        err_act   = '0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = S_WR;
                    idx_d     = 8'd0;
                    addr_d    = BASE_ADDR;
                    mode_d    = mode;
                    seed_d    = seed;
                    awv_d     = 1'b1;
                    wv_d      = 1'b1;
                    done_d    = 1'b0;
                    tmo_d     = 1'b0;
                    err_cnt_d = 8'd0;
                    fe_idx_d  = 8'd0;
                    fe_exp_d  = '0;
                    fe_act_d  = '0;
                    fe_type_d = 2'd0;
                end
            end
            S_WR: begin
                // AW and W may complete in different cycles; each valid drops on its own
                awv_d = awv_q && !m_axi_awready;
                wv_d  = wv_q && !m_axi_wready;
                if (!awv_d && !wv_d) state_d = S_WB;
            end
            S_WB: begin
                if (m_axi_bvalid) begin
                    if (m_axi_bresp != 2'b00) begin
                        err_ev = 1'b1;
                        err_ty = 2'd1;
                    end
                    state_d = S_RA;
                    arv_d   = 1'b1;
                end
            end
            S_RA: begin
                arv_d = arv_q && !m_axi_arready;
                if (!arv_d) state_d = S_RD;
            end
            S_RD: begin
                if (m_axi_rvalid) begin
                    rdata_d = m_axi_rdata;
                    rresp_d = m_axi_rresp;
                    state_d = S_CMP;
                end
            end
            S_CMP: begin
                if (rresp_q != 2'b00) begin
                    err_ev  = 1'b1;
                    err_ty  = 2'd2;
                    err_act = rdata_q;
                end else if (rdata_q != exp_data) begin
                    err_ev  = 1'b1;
                    err_ty  = 2'd3;
                    err_act = rdata_q;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    addr_d  = addr_q + ADDR_WIDTH'(ADDR_STRIDE);
                    awv_d   = 1'b1;
                    wv_d    = 1'b1;
                    state_d = S_WR;
                end
            end
            default: begin
                // HANG: everything held, including any outstanding valid, until reset
            end
        endcase

        if (err_ev) begin
            if (err_cnt_q == 8'd0) begin
                fe_idx_d  = idx_q;
                fe_exp_d  = exp_data;
                fe_act_d  = err_act;
                fe_type_d = err_ty;
            end
            err_cnt_d = sat_inc(err_cnt_q);
        end

        wait_state = (state_q == S_WR) || (state_q == S_WB) ||
                     (state_q == S_RA) || (state_q == S_RD);
        if (wait_state && (state_d == state_q) && (tcnt_q == TMO_LAST)) begin
            state_d = S_HANG;
            tmo_d   = 1'b1;
            done_d  = 1'b1;
        end

        if (state_d != state_q) tcnt_d = '0;
        else if (tcnt_q == TMO_LAST) tcnt_d = tcnt_q;
        else tcnt_d = tcnt_q + 1'b1;
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q   <= S_IDLE;
            idx_q     <= 8'd0;
            addr_q    <= '0;
            mode_q    <= 2'd0;
            seed_q    <= '0;
            awv_q     <= 1'b0;
            wv_q      <= 1'b0;
            arv_q     <= 1'b0;
            done_q    <= 1'b0;
            tmo_q     <= 1'b0;
            tcnt_q    <= '0;
            rdata_q   <= '0;
            rresp_q   <= 2'd0;
            err_cnt_q <= 8'd0;
            fe_idx_q  <= 8'd0;
            fe_exp_q  <= '0;
            fe_act_q  <= '0;
            fe_type_q <= 2'd0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            addr_q    <= addr_d;
            mode_q    <= mode_d;
            seed_q    <= seed_d;
            awv_q     <= awv_d;
            wv_q      <= wv_d;
            arv_q     <= arv_d;
            done_q    <= done_d;
            tmo_q     <= tmo_d;
            tcnt_q    <= tcnt_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            err_cnt_q <= err_cnt_d;
            fe_idx_q  <= fe_idx_d;
            fe_exp_q  <= fe_exp_d;
            fe_act_q  <= fe_act_d;
            fe_type_q <= fe_type_d;
        end
    end

    assign busy    = (state_q == S_WR) || (state_q == S_WB) || (state_q == S_RA) ||
                     (state_q == S_RD) || (state_q == S_CMP);
    assign done    = done_q;
    assign timeout = tmo_q;
    assign pass    = done_q && !tmo_q && (err_cnt_q == 8'd0);

    assign err_count          = err_cnt_q;
    assign first_err_index    = fe_idx_q;
    assign first_err_expected = fe_exp_q;
    assign first_err_actual   = fe_act_q;
    assign first_err_type     = fe_type_q;

    // Strobe follows wvalid so the bus reads all-zero out of reset
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = awv_q;
    assign m_axi_wdata   = exp_data;
    assign m_axi_wstrb   = {(DATA_WIDTH/8){wv_q}};
    assign m_axi_wvalid  = wv_q;
    assign m_axi_bready  = (state_q == S_WB);
    assign m_axi_araddr  = addr_q;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = arv_q;
    assign m_axi_rready  = (state_q == S_RD);

endmodule

// File: tb/tb_axil_reg_walker.sv
// Directed bench for axil_reg_walker: two walkers (4-register window, 256-register
// wrapping window), each on a behavioural AXI4-Lite RAM slave with fault knobs.
module tb_axil_reg_walker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int ncmp = 0;
    int nfail = 0;

    logic        rst [2];
    logic        start [2];
    logic [1:0]  mode [2];
    logic [31:0] seed [2];
    logic        busy [2], done [2], pass [2], timeout [2];
    logic [7:0]  err_count [2], fe_idx [2];
    logic [31:0] fe_exp [2], fe_act [2];
    logic [1:0]  fe_type [2];
    logic [31:0] awaddr [2], wdata [2], araddr [2], rdata [2];
    logic [2:0]  awprot [2], arprot [2];
    logic [3:0]  wstrb [2];
    logic        awvalid [2], awready [2], wvalid [2], wready [2];
    logic        bvalid [2], bready [2], arvalid [2], arready [2], rvalid [2], rready [2];
    logic [1:0]  bresp [2], rresp [2];

    int   aw_delay [2];
    int   berr_idx [2];
    int   rerr_idx [2];
    int   stuck_idx [2];
    logic ar_block [2];

    for (genvar s = 0; s < 2; s++) begin : g_slv
        localparam logic [31:0] BASE = (s == 0) ? 32'h43C0_0000 : 32'hFFFF_FF00;
        logic [31:0] mem [256];
        logic [31:0] wlog [256];
        int          wcnt, aw_cnt;
        logic        got_aw, got_w, bv, rv;
        logic [31:0] aw_a, w_d, rd;
        logic [1:0]  br, rr;
        logic        aw_hs, w_hs, ar_hs, do_wr;
        logic [31:0] wa, wd;
        logic [7:0]  widx, ridx;

        assign awready[s] = awvalid[s] && (aw_cnt >= aw_delay[s]);
        assign wready[s]  = wvalid[s];
        assign arready[s] = arvalid[s] && !ar_block[s];
        assign aw_hs = awvalid[s] && awready[s];
        assign w_hs  = wvalid[s] && wready[s];
        assign ar_hs = arvalid[s] && arready[s];
        assign wa    = aw_hs ? awaddr[s] : aw_a;
        assign wd    = w_hs ? wdata[s] : w_d;
        assign do_wr = (aw_hs || got_aw) && (w_hs || got_w);
        assign widx  = 8'((wa - BASE) >> 2);
        assign ridx  = 8'((araddr[s] - BASE) >> 2);
        assign bvalid[s] = bv;
        assign bresp[s]  = br;
        assign rvalid[s] = rv;
        assign rdata[s]  = rd;
        assign rresp[s]  = rr;

        always @(posedge clk) begin
            if (rst[s]) begin
                got_aw <= 1'b0; got_w <= 1'b0; bv <= 1'b0; rv <= 1'b0;
                wcnt <= 0; aw_cnt <= 0; br <= 2'b00; rr <= 2'b00; rd <= 32'h0;
                aw_a <= 32'h0; w_d <= 32'h0;
            end else begin
                if (aw_hs) aw_cnt <= 0;
                else if (awvalid[s]) aw_cnt <= aw_cnt + 1;
                if (aw_hs) aw_a <= awaddr[s];
                if (w_hs) w_d <= wdata[s];
                if (bv && bready[s]) bv <= 1'b0;
                if (do_wr) begin
                    got_aw <= 1'b0;
                    got_w  <= 1'b0;
                    mem[widx] <= wd;
                    wlog[wcnt[7:0]] <= wa;
                    wcnt <= wcnt + 1;
                    bv <= 1'b1;
                    br <= (int'(widx) == berr_idx[s]) ? 2'b10 : 2'b00;
                end else begin
                    if (aw_hs) got_aw <= 1'b1;
                    if (w_hs) got_w <= 1'b1;
                end
                if (rv && rready[s]) rv <= 1'b0;
                if (ar_hs) begin
                    rv <= 1'b1;
                    rd <= (int'(ridx) == stuck_idx[s]) ? 32'h0 : mem[ridx];
                    rr <= (int'(ridx) == rerr_idx[s]) ? 2'b10 : 2'b00;
                end
            end
        end

        axil_reg_walker #(
            .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS((s == 0) ? 4 : 256),
            .BASE_ADDR(BASE), .ADDR_STRIDE(4), .TIMEOUT_CYCLES((s == 0) ? 16 : 256)
        ) u_dut (
            .ACLK(clk), .ARESET(rst[s]), .start(start[s]), .mode(mode[s]), .seed(seed[s]),
            .busy(busy[s]), .done(done[s]), .pass(pass[s]), .timeout(timeout[s]),
            .err_count(err_count[s]), .first_err_index(fe_idx[s]),
            .first_err_expected(fe_exp[s]), .first_err_actual(fe_act[s]),
            .first_err_type(fe_type[s]),
            .m_axi_awaddr(awaddr[s]), .m_axi_awprot(awprot[s]),
            .m_axi_awvalid(awvalid[s]), .m_axi_awready(awready[s]),
            .m_axi_wdata(wdata[s]), .m_axi_wstrb(wstrb[s]),
            .m_axi_wvalid(wvalid[s]), .m_axi_wready(wready[s]),
            .m_axi_bresp(bresp[s]), .m_axi_bvalid(bvalid[s]), .m_axi_bready(bready[s]),
            .m_axi_araddr(araddr[s]), .m_axi_arprot(arprot[s]),
            .m_axi_arvalid(arvalid[s]), .m_axi_arready(arready[s]),
            .m_axi_rdata(rdata[s]), .m_axi_rresp(rresp[s]),
            .m_axi_rvalid(rvalid[s]), .m_axi_rready(rready[s])
        );
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Mode/seed are scrambled right after the start edge to prove they were latched
    task automatic do_start(input int s, input logic [1:0] m, input logic [31:0] sd);
        mode[s] = m; seed[s] = sd; start[s] = 1'b1;
        tick();
        start[s] = 1'b0; mode[s] = ~m; seed[s] = ~sd;
    endtask

    task automatic wait_done(input int s, input int n0, input int limit, output int n);
        n = n0;
        while (!done[s] && n < limit) begin
            tick();
            n++;
        end
        chk("done_reached", done[s], 1'b1);
    endtask

    task automatic chk_idle(input int s, input string tag);
        chk({tag, "_busy"}, busy[s], 1'b0);
        chk({tag, "_done"}, done[s], 1'b0);
        chk({tag, "_pass"}, pass[s], 1'b0);
        chk({tag, "_timeout"}, timeout[s], 1'b0);
        chk({tag, "_err"}, err_count[s], 8'd0);
        chk({tag, "_awvalid"}, awvalid[s], 1'b0);
        chk({tag, "_wvalid"}, wvalid[s], 1'b0);
        chk({tag, "_arvalid"}, arvalid[s], 1'b0);
        chk({tag, "_bready"}, bready[s], 1'b0);
        chk({tag, "_rready"}, rready[s], 1'b0);
        chk({tag, "_awaddr"}, awaddr[s], 32'h0);
        chk({tag, "_fe_type"}, fe_type[s], 2'd0);
    endtask

    initial begin
        int n, na, nw, wc0, seen, g;
        for (int s = 0; s < 2; s++) begin
            rst[s] = 1'b1; start[s] = 1'b0; mode[s] = 2'd0; seed[s] = 32'h0;
            aw_delay[s] = 0; berr_idx[s] = -1; rerr_idx[s] = -1; stuck_idx[s] = -1;
            ar_block[s] = 1'b0;
        end
        repeat (3) tick();
        rst[0] = 1'b0; rst[1] = 1'b0;
        chk_idle(0, "reset0");
        chk_idle(1, "reset1");

        // Clean sweep, with a stray start while busy that must be ignored
        do_start(0, 2'd0, 32'hDEAD_0011);
        chk("clean_busy", busy[0], 1'b1);
        chk("clean_awvalid", awvalid[0], 1'b1);
        chk("clean_wvalid", wvalid[0], 1'b1);
        chk("clean_awprot", awprot[0], 3'd0);
        repeat (4) tick();
        start[0] = 1'b1; tick(); start[0] = 1'b0;
        wait_done(0, 6, 200, n);
        chk("clean_latency", n, 21);
        chk("clean_pass", pass[0], 1'b1);
        chk("clean_err", err_count[0], 8'd0);
        chk("clean_busy_end", busy[0], 1'b0);
        chk("clean_addr0", g_slv[0].wlog[0], 32'h43C0_0000);
        chk("clean_addr1", g_slv[0].wlog[1], 32'h43C0_0004);
        chk("clean_addr2", g_slv[0].wlog[2], 32'h43C0_0008);
        chk("clean_addr3", g_slv[0].wlog[3], 32'h43C0_000C);
        chk("clean_mem3", g_slv[0].mem[3], 32'hDEAD_0011);

        // Stuck register 2
        stuck_idx[0] = 2;
        do_start(0, 2'd1, 32'hABCD_0001);
        chk("stuck_done_clr", done[0], 1'b0);
        wait_done(0, 1, 200, n);
        chk("stuck_err", err_count[0], 8'd1);
        chk("stuck_idx", fe_idx[0], 8'd2);
        chk("stuck_exp", fe_exp[0], 32'hABCD_0003);
        chk("stuck_act", fe_act[0], 32'h0);
        chk("stuck_type", fe_type[0], 2'd3);
        chk("stuck_pass", pass[0], 1'b0);
        stuck_idx[0] = -1;

        // Response errors: SLVERR on write of reg 1, on read of reg 3
        berr_idx[0] = 1; rerr_idx[0] = 3;
        do_start(0, 2'd2, 32'h1234_5678);
        chk("resp_err_clr", err_count[0], 8'd0);
        chk("resp_type_clr", fe_type[0], 2'd0);
        wait_done(0, 1, 200, n);
        chk("resp_err", err_count[0], 8'd2);
        chk("resp_idx", fe_idx[0], 8'd1);
        chk("resp_type", fe_type[0], 2'd1);
        chk("resp_exp", fe_exp[0], 32'h0000_0002);
        chk("resp_act", fe_act[0], 32'h0);
        chk("resp_pass", pass[0], 1'b0);
        chk("resp_mem3", g_slv[0].mem[3], 32'h0000_0008);
        berr_idx[0] = -1; rerr_idx[0] = -1;

        // Backpressure: awready 3 cycles late, wready immediate
        aw_delay[0] = 3;
        wc0 = g_slv[0].wcnt;
        do_start(0, 2'd0, 32'h5A5A_5A5A);
        chk("bp_wstrb", wstrb[0], 4'hF);
        na = 0; nw = 0;
        for (int c = 0; c < 6; c++) begin
            if (awvalid[0]) na++;
            if (wvalid[0]) nw++;
            if (c < 5) tick();
        end
        chk("bp_aw_cycles", na, 4);
        chk("bp_w_cycles", nw, 1);
        wait_done(0, 6, 300, n);
        chk("bp_latency", n, 33);
        chk("bp_writes", g_slv[0].wcnt - wc0, 4);
        chk("bp_pass", pass[0], 1'b1);
        aw_delay[0] = 0;

        // Timeout: arready held low
        ar_block[0] = 1'b1;
        do_start(0, 2'd0, 32'h0);
        g = 0;
        while (!arvalid[0] && g < 10) begin tick(); g++; end
        chk("tmo_ra_entered", arvalid[0], 1'b1);
        n = 1;
        while (!done[0] && n < 100) begin
            tick();
            if (!done[0]) n++;
        end
        chk("tmo_ra_cycles", n, 16);
        chk("tmo_timeout", timeout[0], 1'b1);
        chk("tmo_done", done[0], 1'b1);
        chk("tmo_busy", busy[0], 1'b0);
        chk("tmo_pass", pass[0], 1'b0);
        chk("tmo_arvalid", arvalid[0], 1'b1);
        start[0] = 1'b1; tick(); start[0] = 1'b0; tick();
        chk("hang_start_done", done[0], 1'b1);
        chk("hang_start_tmo", timeout[0], 1'b1);
        chk("hang_start_busy", busy[0], 1'b0);
        chk("hang_start_aw", awvalid[0], 1'b0);
        chk("hang_start_ar", arvalid[0], 1'b1);
        rst[0] = 1'b1; tick(); rst[0] = 1'b0;
        ar_block[0] = 1'b0;
        chk_idle(0, "hang_reset");

        // Abort during RD of register 1 on the wrapping walker, then restart
        do_start(1, 2'd0, 32'h1111_2222);
        seen = 0; g = 0;
        while (seen < 2 && g < 50) begin
            if (rready[1]) seen++;
            if (seen < 2) begin tick(); g++; end
        end
        chk("abort_in_rd", seen, 2);
        rst[1] = 1'b1; tick(); rst[1] = 1'b0;
        chk_idle(1, "abort");
        repeat (3) tick();
        chk("abort_no_resume_aw", awvalid[1], 1'b0);
        chk("abort_no_resume_busy", busy[1], 1'b0);
        do_start(1, 2'd3, 32'h0F0F_0F0F);
        chk("wrap_first_addr", awaddr[1], 32'hFFFF_FF00);
        wait_done(1, 1, 2000, n);
        chk("wrap_latency", n, 1281);
        chk("wrap_pass", pass[1], 1'b1);
        chk("wrap_err", err_count[1], 8'd0);
        chk("wrap_timeout", timeout[1], 1'b0);
        chk("wrap_addr0", g_slv[1].wlog[0], 32'hFFFF_FF00);
        chk("wrap_addr63", g_slv[1].wlog[63], 32'hFFFF_FFFC);
        chk("wrap_addr64", g_slv[1].wlog[64], 32'h0000_0000);
        chk("wrap_addr255", g_slv[1].wlog[255], 32'h0000_02FC);
        chk("wrap_mem64", g_slv[1].mem[64], 32'hF0F0_F0B0);
        chk("wrap_mem255", g_slv[1].mem[255], 32'hF0F0_EFF1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/axil_reg_walker.md
# axil_reg_walker

Synthesizable AXI4-Lite master that runs a write/read-back/compare sweep across a parametrised window of slave registers and reports pass/fail with first-error capture. It replaces bench-only register checks on IP such as the step generator, so the same check runs on silicon. It is instantiated beside the interconnect as an extra master and is driven by a start pulse from a control register or debug core.

## Interface

**Parameters**
- `ADDR_WIDTH`, default 32: AXI address width.
- `DATA_WIDTH`, default 32: AXI data width. Legal values are 32 and 64.
- `NUM_REGS`, default 4: registers swept, range 1..256.
- `BASE_ADDR`, default 0: address of register 0.
- `ADDR_STRIDE`, default 4: byte step between registers.
- `TIMEOUT_CYCLES`, default 256: maximum cycles spent in any single wait state.

**Ports**
- `ACLK`, in, 1: clock.
- `ARESET`, in, 1: synchronous, active-high reset.
- `start`, in, 1: begin a sweep. Sampled only in IDLE or DONE.
- `mode`, in, 2: pattern select. 0 = `seed`; 1 = `seed+i`; 2 = `1<<(i mod DATA_WIDTH)`; 3 = `~(seed+i)`.
- `seed`, in, DATA_WIDTH: pattern seed. Latched together with `mode` at start.
- `busy`, out, 1: sweep in progress.
- `done`, out, 1: level signal. Held until the next accepted start.
- `pass`, out, 1: 1 when `err_count`=0 and `timeout`=0. Valid only while `done`=1.
- `timeout`, out, 1: a wait state exceeded `TIMEOUT_CYCLES`.
- `err_count`, out, 8: count of errors, saturating at 255.
- `first_err_index`, out, 8: register index of the first error.
- `first_err_expected`, out, DATA_WIDTH: expected data at the first error.
- `first_err_actual`, out, DATA_WIDTH: actual data at the first error.
- `first_err_type`, out, 2: 1 = BRESP not OKAY; 2 = RRESP not OKAY; 3 = data mismatch.
- `m_axi_awaddr`/`awprot`/`awvalid`/`awready`: AW channel. Prot is always 0.
- `m_axi_wdata`/`wstrb`/`wvalid`/`wready`: W channel. Strobe is all ones.
- `m_axi_bresp`/`bvalid`/`bready`: B channel.
- `m_axi_araddr`/`arprot`/`arvalid`/`arready`: AR channel. Prot is always 0.
- `m_axi_rdata`/`rresp`/`rvalid`/`rready`: R channel.

## Operation

- **FSM states:** IDLE, WR, WB, RA, RD, CMP, DONE, HANG.
- **IDLE/DONE → WR:** on `start`. This clears the index, all error outputs, `done` and `timeout`, and latches `mode` and `seed`.
- **WR:** assert `awvalid` and `wvalid` together. Each valid drops independently on its own handshake. Leave WR once both handshakes have completed, which may happen in different cycles.
- **WB:** `bready`=1. When `bvalid` is seen, a `bresp`≠0 is an error (type 1). Go to RA.
- **RA:** `arvalid`=1 until `arready`.
- **RD:** `rready`=1. When `rvalid` is seen, register `rdata` and `rresp`.
- **CMP:**
  - `rresp`≠0 is an error of type 2, and the data compare is skipped.
  - Otherwise, if data ≠ expected, it is an error of type 3.
  - Then increment the index. Go to WR, or to DONE after index `NUM_REGS-1`.
- **Error counting:** at most one error is counted per register phase. A register can therefore add up to 2 errors: one from WB and one from CMP.
- **First error capture:** `first_err_*` is written only while `err_count`=0.
  - For type 1, expected is the written data and actual is 0.
- **Address** = `BASE_ADDR + i*ADDR_STRIDE`, truncated to `ADDR_WIDTH`, wrapping modulo 2^ADDR_WIDTH.
- **Pattern sums** wrap modulo 2^DATA_WIDTH.
- **Timeout:** the counter resets on every state entry.
  - Expiry in WR, WB, RA or RD sets `timeout`=1 and `done`=1, clears `busy`, and enters HANG.
  - In HANG, any valid already asserted stays asserted, as AXI requires. HANG is exited only by `ARESET`.
- **start** is ignored while `busy`=1 and in HANG.

## Timing

- **Reset values:** all outputs are 0, including every valid/ready, `done`, `busy` and `pass`. State is IDLE.
- **Reset mid-sweep:** all outputs are 0 in the cycle after `ARESET` is sampled high. No transaction is resumed.
- **Start response:** `start` sampled at edge k gives `busy`=1 and `awvalid`=`wvalid`=1 from k+1.
- **Minimum cost per register:** 5 cycles (WR, WB, RA, RD, CMP), when the slave answers in the first cycle of each state.
- **Completion:** `done`=1 and `busy`=0 in the cycle after the last CMP.
- **Pipelining:** none. Only one AXI transaction is outstanding at any time.

## Test plan

- **Clean sweep:** RAM slave, `NUM_REGS`=4, `BASE_ADDR`=0x43C00000, mode 0, seed 0xDEAD0011 → writes go to 0x43C00000/4/8/C; `pass`=1, `err_count`=0; `done` rises 21 cycles after start with a zero-wait slave.
- **Stuck register:** mode 1, seed 0xABCD0001, slave register 2 reads 0 → `err_count`=1, `first_err_index`=2, expected 0xABCD0003, actual 0, type 3, `pass`=0.
- **Response errors:** BRESP=SLVERR on register 1 and RRESP=SLVERR on register 3, mode 2 → `err_count`=2, `first_err_index`=1, type 1, expected 0x00000002.
- **Backpressure:** `awready` delayed 3 cycles, `wready` immediate → `wvalid` drops after 1 cycle, `awvalid` is held 4 cycles, single write, `pass`=1.
- **Timeout:** `arready` held low, `TIMEOUT_CYCLES`=16 → `timeout`=1 and `done`=1 after 16 RA cycles; `arvalid` stays 1; a `start` pulse has no effect; `ARESET` returns all outputs to 0.
- **Abort and restart:** `ARESET` asserted during the RD of register 1, then a fresh start with `NUM_REGS`=256 and `ADDR_STRIDE`=4 starting at 0xFFFFFF00 → addresses wrap to 0x00000000 at index 64; `pass`=1, `err_count` stays 0.
